// File: rtl/packet_fifo_write_arbiter.sv
// Round-robin arbiter that funnels packets from NUM_REQ sources into one FIFO
// write port, holding each accepted packet until the FIFO can take it.
module packet_fifo_write_arbiter #(
  parameter int unsigned PACKET_SIZE_BITS = 256,
  parameter int unsigned NUM_REQ          = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*PACKET_SIZE_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                full,
  output logic                                wr_en,
  output logic [PACKET_SIZE_BITS-1:0]         din,
  output logic [2:0]                          grant_id,
  output logic [15:0]                         pkt_count,
  output logic [15:0]                         stall_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;

  logic [2:0]                    r_rr_ptr;
  logic [2:0]                    r_grant_id;
  logic [PACKET_SIZE_BITS-1:0]   r_din;
  logic [15:0]                   r_pkt_count;
  logic [15:0]                   r_stall_count;

  logic [2*NUM_REQ-1:0]          w_valid_rot;
  logic                          w_sel_found;
  logic [2:0]                    w_sel_idx;
  logic [PACKET_SIZE_BITS-1:0]   w_sel_data;
  logic                          w_accept;
  logic                          w_write;
  logic                          w_stall;
  logic [2:0]                    w_rr_next;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the first
  // set bit found scanning upward is the round-robin winner.
  assign w_valid_rot = {req_valid, req_valid} >> r_rr_ptr;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_sel_found && w_valid_rot[k]) begin
        w_sel_found = 1'b1;
        if (32'(r_rr_ptr) + k >= NUM_REQ) begin
          w_sel_idx = 3'(32'(r_rr_ptr) + k - NUM_REQ);
        end else begin
          w_sel_idx = 3'(32'(r_rr_ptr) + k);
        end
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (w_sel_idx == 3'(j)) begin
        w_sel_data = req_data[j*PACKET_SIZE_BITS +: PACKET_SIZE_BITS];
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && w_sel_found;
  assign w_write   = (r_state == WRITE) && !full;
  assign w_stall   = (r_state == WRITE) && full;
  assign w_rr_next = (r_grant_id == 3'(NUM_REQ - 1)) ? '0 : r_grant_id + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_sel_found) w_state_next = WRITE;
      WRITE:   if (!full)       w_state_next = IDLE;
      default:                  w_state_next = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so nothing is offered or written while reset is held.
  always_comb begin
    req_ready = '0;
    wr_en     = 1'b0;
    if (rst_n) begin
      wr_en = w_write;
      if (w_accept) begin
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
          req_ready[j] = (w_sel_idx == 3'(j));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_din         <= '0;
      r_pkt_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_accept) begin
        r_din      <= w_sel_data;
        r_grant_id <= w_sel_idx;
      end
      if (w_write) begin
        r_rr_ptr    <= w_rr_next;
        r_pkt_count <= r_pkt_count + 16'd1;
      end
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign din         = r_din;
  assign grant_id    = r_grant_id;
  assign pkt_count   = r_pkt_count;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_packet_fifo_write_arbiter.sv
// Directed bench for packet_fifo_write_arbiter: a packet-level model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_packet_fifo_write_arbiter;

  localparam int unsigned W = 256;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           full;
  logic           wr_en;
  logic [W-1:0]   din;
  logic [2:0]     grant_id;
  logic [15:0]    pkt_count;
  logic [15:0]    stall_count;

  always #5 clk = ~clk;

  packet_fifo_write_arbiter #(
    .PACKET_SIZE_BITS(W),
    .NUM_REQ(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .full(full),
    .wr_en(wr_en),
    .din(din),
    .grant_id(grant_id),
    .pkt_count(pkt_count),
    .stall_count(stall_count)
  );

  // Packet-level model: "holding a packet or not", the held packet, and counters.
  bit          m_hold;
  logic [W-1:0] m_din;
  int unsigned m_gid, m_rr, m_pkt, m_stall;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned wlog_gid[$];
  logic [W-1:0] wlog_din[$];

  function automatic logic [W-1:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold  = 0;
    m_din   = '0;
    m_gid   = 0;
    m_rr    = 0;
    m_pkt   = 0;
    m_stall = 0;
  endtask

  function automatic int unsigned m_pick();
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned i;
      i = (m_rr + k) % N;
      if (req_valid[i]) return i;
    end
    return N;
  endfunction

  // Compare at the falling edge, then advance the model with the inputs that
  // the DUT will see at the next rising edge.
  task automatic tick();
    int unsigned sel;
    logic [N-1:0] exp_ready;
    logic         exp_wr;
    @(negedge clk);
    if (!rst_n) model_reset();
    sel       = m_pick();
    exp_ready = (rst_n && !m_hold && sel < N) ? (N'(1) << sel) : '0;
    exp_wr    = rst_n && m_hold && !full;
    chk("req_ready", W'(req_ready), W'(exp_ready));
    chk("wr_en", W'(wr_en), W'(exp_wr));
    chk("din", din, m_din);
    chk("grant_id", W'(grant_id), W'(m_gid));
    chk("pkt_count", W'(pkt_count), W'(m_pkt));
    chk("stall_count", W'(stall_count), W'(m_stall));
    if (wr_en) begin
      wlog_gid.push_back(32'(grant_id));
      wlog_din.push_back(din);
    end
    if (rst_n) begin
      if (m_hold) begin
        if (!full) begin
          m_hold = 0;
          m_rr   = (m_gid + 1) % N;
          m_pkt  = (m_pkt + 1) % 65536;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end else if (sel < N) begin
        m_hold = 1;
        m_gid  = sel;
        m_din  = req_data[sel*W +: W];
      end
    end
    @(posedge clk);
    #1;
  endtask

  int unsigned base;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    model_reset();
    #1;
    repeat (2) tick();
    chk("rst_pkt", W'(pkt_count), W'(0));
    chk("rst_wr_en", W'(wr_en), W'(0));

    // Single packet, one-cycle latency to the write.
    rst_n = 1'b1;
    tick();
    req_valid = 4'b0001;
    req_data[0 +: W] = pat(32'hAAAA_0001);
    #1 chk("s1_ready_c0", W'(req_ready), W'(4'b0001));
    tick();
    req_valid = '0;
    #1;
    chk("s1_wr_en_c1", W'(wr_en), W'(1));
    chk("s1_din_c1", din, pat(32'hAAAA_0001));
    chk("s1_gid_c1", W'(grant_id), W'(0));
    tick();
    chk("s1_pkt", W'(pkt_count), W'(1));

    // All four requesting for eight packets.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < N; i++) req_data[i*W +: W] = pat(32'hB000_0000 + i);
    req_valid = 4'b1111;
    base = wlog_gid.size();
    repeat (16) tick();
    req_valid = '0;
    tick();
    chk("s2_nwrites", W'(wlog_gid.size() - base), W'(8));
    for (int unsigned k = 0; k < 8; k++) begin
      if (base + k < wlog_gid.size()) begin
        chk("s2_order", W'(wlog_gid[base+k]), W'(k % 4));
        chk("s2_data", wlog_din[base+k], pat(32'hB000_0000 + (k % 4)));
      end
    end
    chk("s2_pkt", W'(pkt_count), W'(8));

    // Wrap-around after a grant to 3.
    req_valid = 4'b1001;
    base = wlog_gid.size();
    repeat (4) tick();
    req_valid = '0;
    tick();
    chk("s3_nwrites", W'(wlog_gid.size() - base), W'(2));
    if (wlog_gid.size() >= base + 2) begin
      chk("s3_wrap", W'(wlog_gid[base]), W'(0));
      chk("s3_next", W'(wlog_gid[base+1]), W'(3));
    end

    // Stall for five cycles on full.
    req_data[2*W +: W] = pat(32'hBBBB_0002);
    req_valid = 4'b0100;
    base = wlog_gid.size();
    tick();
    full = 1'b1;
    req_valid = 4'b1111;
    for (int unsigned k = 0; k < 5; k++) begin
      #1;
      chk("s4_ready", W'(req_ready), W'(0));
      chk("s4_wr_en", W'(wr_en), W'(0));
      chk("s4_din", din, pat(32'hBBBB_0002));
      tick();
    end
    full = 1'b0;
    req_valid = '0;
    #1 chk("s4_wr_release", W'(wr_en), W'(1));
    tick();
    chk("s4_stall", W'(stall_count), W'(5));
    chk("s4_nwrites", W'(wlog_gid.size() - base), W'(1));
    if (wlog_gid.size() > base) chk("s4_wdata", wlog_din[base], pat(32'hBBBB_0002));

    // Reset while holding a stalled packet.
    req_data[1*W +: W] = pat(32'hCCCC_0001);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    full = 1'b1;
    tick();
    base = wlog_gid.size();
    rst_n = 1'b0;
    #1;
    chk("s5_wr_en", W'(wr_en), W'(0));
    chk("s5_din", din, '0);
    chk("s5_gid", W'(grant_id), W'(0));
    chk("s5_pkt", W'(pkt_count), W'(0));
    chk("s5_stall", W'(stall_count), W'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    full = 1'b0;
    chk("s5_no_write", W'(wlog_gid.size() - base), W'(0));
    req_valid = 4'b1111;
    #1 chk("s5_ready", W'(req_ready), W'(4'b0001));
    repeat (2) tick();
    req_valid = '0;
    tick();
    chk("s5_nwrites", W'(wlog_gid.size() - base), W'(1));
    if (wlog_gid.size() > base) chk("s5_gid_after", W'(wlog_gid[base]), W'(0));

    // pkt_count wraps from 16'hFFFF.
    force dut.r_pkt_count = 16'hFFFF;
    m_pkt = 65535;
    tick();
    release dut.r_pkt_count;
    chk("s6_pkt_forced", W'(pkt_count), W'(16'hFFFF));
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    chk("s6_pkt_wrap", W'(pkt_count), W'(0));

    // stall_count saturates.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    full = 1'b1;
    repeat (65540) tick();
    chk("s7_stall_sat", W'(stall_count), W'(16'hFFFF));
    full = 1'b0;
    tick();
    chk("s7_stall_hold", W'(stall_count), W'(16'hFFFF));
    chk("s7_pkt", W'(pkt_count), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
